// File: rtl/tx_ctrl_encoder_pkg.sv
// Shared C-PHY LP control definitions: sequencer states, line levels, CtrlCode values.
// Used by the Tx sequencer and the Rx control decoder.
package cphy_ctrl_pkg;

    typedef enum logic [2:0] {
        STOP,
        HS_RQST,
        HS_PREP,
        HS,
        HS_EXIT,
        LP_RQST,
        TA_RQST,
        TA_GO
    } ctrlState_t;

    // Line levels, ordered {A, B, C}
    localparam logic [2:0] LP_STOP    = 3'b111;
    localparam logic [2:0] LP_HS_RQST = 3'b001;
    localparam logic [2:0] LP_BRIDGE  = 3'b000;
    localparam logic [2:0] LP_LP_RQST = 3'b100;

    localparam logic [1:0] CODE_STOP    = 2'b00;
    localparam logic [1:0] CODE_HS_RQST = 2'b01;
    localparam logic [1:0] CODE_BRIDGE  = 2'b10;
    localparam logic [1:0] CODE_LP_RQST = 2'b11;

    typedef struct packed {
        logic [2:0] abc;
        logic       lpOe;
        logic       hsEn;
        logic       busy;
        logic [1:0] code;
        logic       taGranted;
    } ctrlOut_t;

    localparam ctrlOut_t OUT_RESET = '{
        abc: LP_STOP, lpOe: 1'b1, hsEn: 1'b0, busy: 1'b0,
        code: CODE_STOP, taGranted: 1'b0
    };

    function automatic ctrlOut_t decodeState(input ctrlState_t s);
        ctrlOut_t o;
        o = '{abc: LP_STOP, lpOe: 1'b1, hsEn: 1'b0, busy: 1'b1,
              code: CODE_STOP, taGranted: 1'b0};
        case (s)
            STOP: begin
                o.busy = 1'b0;
            end
            HS_RQST: begin
                o.abc  = LP_HS_RQST;
                o.code = CODE_HS_RQST;
            end
            HS_PREP, TA_RQST: begin
                o.abc  = LP_BRIDGE;
                o.code = CODE_BRIDGE;
            end
            HS: begin
                o.abc  = LP_BRIDGE;
                o.lpOe = 1'b0;
                o.hsEn = 1'b1;
                o.code = CODE_BRIDGE;
            end
            HS_EXIT: begin
                o.abc  = LP_STOP;
            end
            LP_RQST: begin
                o.abc  = LP_LP_RQST;
                o.code = CODE_LP_RQST;
            end
            TA_GO: begin
                o.abc       = LP_BRIDGE;
                o.lpOe      = 1'b0;
                o.code      = CODE_BRIDGE;
                o.taGranted = 1'b1;
            end
            default: o = OUT_RESET;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/tx_ctrl_encoder_if.sv
// LP control handshake and line bundle between the Tx sequencer (master)
// and the PHY front end / HS serializer side (slave).
interface tx_ctrl_encoder_if;
    logic       TxCtrlEn;
    logic       HsReq;
    logic       HsDone;
    logic       TaReq;
    logic       TaReturn;
    logic       A;
    logic       B;
    logic       C;
    logic       LpOe;
    logic       HsEn;
    logic       Busy;
    logic [1:0] CtrlCode;
    logic       TaGranted;

    modport master (
        input  TxCtrlEn, HsReq, HsDone, TaReq, TaReturn,
        output A, B, C, LpOe, HsEn, Busy, CtrlCode, TaGranted
    );

    modport slave (
        output TxCtrlEn, HsReq, HsDone, TaReq, TaReturn,
        input  A, B, C, LpOe, HsEn, Busy, CtrlCode, TaGranted
    );
endinterface

// File: rtl/tx_ctrl_encoder_dwell_cnt.sv
// Loadable dwell down-counter; saturates at zero and flags it.
module tx_ctrl_dwell_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    output logic             zero
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/tx_ctrl_encoder.sv
// Master-side C-PHY LP control sequencer: Stop -> HS-Rqst -> HS-Prep -> HS -> Stop.
// Optional turnaround states are built when TX_TA_EN is defined.
module tx_ctrl_encoder
    import cphy_ctrl_pkg::*;
#(
    parameter int unsigned T_HS_RQST_CYC = 8,
    parameter int unsigned T_HS_PREP_CYC = 6,
    parameter int unsigned T_HS_EXIT_CYC = 10,
    parameter int unsigned T_LP_RQST_CYC = 4,
    parameter int unsigned T_TA_RQST_CYC = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_ctrl_encoder_if.master    ctrl
);
    localparam longint unsigned CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (CNT_W == 0) begin : gBadCntW
        $fatal(1, "tx_ctrl_encoder: CNT_W must be nonzero");
    end
    if (T_HS_RQST_CYC == 0 || T_HS_RQST_CYC > CNT_MAX) begin : gBadHsRqst
        $fatal(1, "tx_ctrl_encoder: T_HS_RQST_CYC out of range");
    end
    if (T_HS_PREP_CYC == 0 || T_HS_PREP_CYC > CNT_MAX) begin : gBadHsPrep
        $fatal(1, "tx_ctrl_encoder: T_HS_PREP_CYC out of range");
    end
    if (T_HS_EXIT_CYC == 0 || T_HS_EXIT_CYC > CNT_MAX) begin : gBadHsExit
        $fatal(1, "tx_ctrl_encoder: T_HS_EXIT_CYC out of range");
    end
    if (T_LP_RQST_CYC == 0 || T_LP_RQST_CYC > CNT_MAX) begin : gBadLpRqst
        $fatal(1, "tx_ctrl_encoder: T_LP_RQST_CYC out of range");
    end
    if (T_TA_RQST_CYC == 0 || T_TA_RQST_CYC > CNT_MAX) begin : gBadTaRqst
        $fatal(1, "tx_ctrl_encoder: T_TA_RQST_CYC out of range");
    end

    ctrlState_t       state;
    ctrlState_t       nextState;
    ctrlOut_t         outReg;
    logic             dwellLoad;
    logic [CNT_W-1:0] dwellVal;
    logic             dwellZero;

    tx_ctrl_dwell_cnt #(
        .CNT_W (CNT_W)
    ) dwellCnt (
        .clk     (clk),
        .rst     (rst),
        .load    (dwellLoad),
        .loadVal (dwellVal),
        .zero    (dwellZero)
    );

    always_comb begin
        nextState = state;
        case (state)
            STOP: begin
                if (ctrl.TxCtrlEn && ctrl.HsReq) begin
                    nextState = HS_RQST;
                end
`ifdef TX_TA_EN
                else if (ctrl.TxCtrlEn && ctrl.TaReq) begin
                    nextState = LP_RQST;
                end
`endif
            end
            HS_RQST: if (dwellZero)   nextState = HS_PREP;
            HS_PREP: if (dwellZero)   nextState = HS;
            HS:      if (ctrl.HsDone) nextState = HS_EXIT;
            HS_EXIT: if (dwellZero)   nextState = STOP;
`ifdef TX_TA_EN
            LP_RQST: if (dwellZero)     nextState = TA_RQST;
            TA_RQST: if (dwellZero)     nextState = TA_GO;
            TA_GO:   if (ctrl.TaReturn) nextState = STOP;
`endif
            default: nextState = STOP;
        endcase
    end

    // Reload on every transition: timed states get T-1, untimed ones park the counter at 0.
    always_comb begin
        dwellLoad = (nextState != state);
        case (nextState)
            HS_RQST: dwellVal = CNT_W'(T_HS_RQST_CYC - 1);
            HS_PREP: dwellVal = CNT_W'(T_HS_PREP_CYC - 1);
            HS_EXIT: dwellVal = CNT_W'(T_HS_EXIT_CYC - 1);
            LP_RQST: dwellVal = CNT_W'(T_LP_RQST_CYC - 1);
            TA_RQST: dwellVal = CNT_W'(T_TA_RQST_CYC - 1);
            default: dwellVal = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= STOP;
            outReg <= OUT_RESET;
        end else begin
            state  <= nextState;
            outReg <= decodeState(nextState);
        end
    end

    assign ctrl.A        = outReg.abc[2];
    assign ctrl.B        = outReg.abc[1];
    assign ctrl.C        = outReg.abc[0];
    assign ctrl.LpOe     = outReg.lpOe;
    assign ctrl.HsEn     = outReg.hsEn;
    assign ctrl.Busy     = outReg.busy;
    assign ctrl.CtrlCode = outReg.code;

`ifdef TX_TA_EN
    assign ctrl.TaGranted = outReg.taGranted;
`else
    logic unusedTa;
    assign unusedTa       = ctrl.TaReq ^ ctrl.TaReturn ^ outReg.taGranted;
    assign ctrl.TaGranted = 1'b0;
`endif

endmodule

// File: tb/tb_tx_ctrl_encoder.sv
// Scoreboard bench for tx_ctrl_encoder: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_tx_ctrl_encoder;

    typedef struct packed {
        logic [2:0] abc;
        logic       lpOe;
        logic       hsEn;
        logic       busy;
        logic [1:0] code;
        logic       taG;
    } obs_t;

    localparam obs_t FULL    = '{3'b111, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1};
    localparam obs_t NO_ABC  = '{3'b000, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1};
    localparam obs_t E_STOP  = '{3'b111, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    localparam obs_t E_RQST  = '{3'b001, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0};
    localparam obs_t E_PREP  = '{3'b000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0};
    localparam obs_t E_HS    = '{3'b000, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
    localparam obs_t E_EXIT  = '{3'b111, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
    localparam obs_t E_LPR   = '{3'b100, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0};
    localparam obs_t E_TAR   = '{3'b000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0};
    localparam obs_t E_TAGO  = '{3'b000, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    obs_t  expQ[$];
    obs_t  maskQ[$];
    string nameQ[$];

    tx_ctrl_encoder_if bus();

    tx_ctrl_encoder #(
        .T_HS_RQST_CYC (8),
        .T_HS_PREP_CYC (6),
        .T_HS_EXIT_CYC (10),
        .T_LP_RQST_CYC (4),
        .T_TA_RQST_CYC (4),
        .CNT_W         (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        obs_t  e;
        obs_t  m;
        obs_t  a;
        string nm;
        if (expQ.size() > 0) begin
            e  = expQ.pop_front();
            m  = maskQ.pop_front();
            nm = nameQ.pop_front();
            a  = '{{bus.A, bus.B, bus.C}, bus.LpOe, bus.HsEn, bus.Busy,
                   bus.CtrlCode, bus.TaGranted};
            tests++;
            if ((a & m) !== (e & m)) begin
                fails++;
                $display("FAIL %s: got abc/oe/hs/busy/code/ta=%b required %b (mask %b) at %0t",
                         nm, a, e, m, $time);
            end
        end
    end

    // Inputs are set by the caller before this; each edge queues the
    // outputs expected right after it.
    task automatic expectN(input int unsigned n, input obs_t e, input obs_t m, input string nm);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            expQ.push_back(e);
            maskQ.push_back(m);
            nameQ.push_back(nm);
            #1;
        end
    endtask

    initial begin
        bus.TxCtrlEn = 1'b0;
        bus.HsReq    = 1'b0;
        bus.HsDone   = 1'b0;
        bus.TaReq    = 1'b0;
        bus.TaReturn = 1'b0;

        expectN(3, E_STOP, FULL, "reset");
        rst = 1'b0;
        expectN(4, E_STOP, FULL, "idleStop");

        // HS entry from a one-cycle request
        bus.TxCtrlEn = 1'b1;
        bus.HsReq    = 1'b1;
        expectN(1, E_RQST, FULL, "hsRqstEntry");
        bus.HsReq = 1'b0;
        expectN(7, E_RQST, FULL, "hsRqstHold");
        expectN(6, E_PREP, FULL, "hsPrep");
        bus.TxCtrlEn = 1'b0;
        expectN(5, E_HS, NO_ABC, "hsBurst");

        // HS exit, with a stray HsDone during exit
        bus.HsDone = 1'b1;
        expectN(1, E_EXIT, FULL, "hsExitEntry");
        bus.HsDone = 1'b0;
        expectN(4, E_EXIT, FULL, "hsExitHold");
        bus.HsDone = 1'b1;
        expectN(1, E_EXIT, FULL, "exitIgnoresDone");
        bus.HsDone = 1'b0;
        expectN(4, E_EXIT, FULL, "hsExitTail");
        expectN(3, E_STOP, FULL, "backToStop");
        bus.HsDone = 1'b1;
        expectN(1, E_STOP, FULL, "doneInStop");
        bus.HsDone = 1'b0;
        expectN(2, E_STOP, FULL, "stopAfterDone");

        // Enable gating, then reset in the third HS_PREP cycle
        bus.HsReq = 1'b1;
        expectN(5, E_STOP, FULL, "gatedByEnable");
        bus.TxCtrlEn = 1'b1;
        expectN(8, E_RQST, FULL, "hsRqst2");
        expectN(3, E_PREP, FULL, "hsPrep2");
        rst       = 1'b1;
        bus.HsReq = 1'b0;
        expectN(1, E_STOP, FULL, "midPrepReset");
        rst = 1'b0;
        expectN(2, E_STOP, FULL, "afterReset");

        // Full restart with HsReq held through exit: one STOP cycle then re-entry
        bus.HsReq = 1'b1;
        expectN(8, E_RQST, FULL, "hsRqstFresh");
        expectN(6, E_PREP, FULL, "hsPrepFresh");
        expectN(3, E_HS, NO_ABC, "hsBurst2");
        bus.HsDone = 1'b1;
        expectN(1, E_EXIT, FULL, "hsExit2");
        bus.HsDone = 1'b0;
        expectN(9, E_EXIT, FULL, "hsExit2Hold");
        expectN(1, E_STOP, FULL, "minStopDwell");
        expectN(2, E_RQST, FULL, "reenterRqst");
        bus.HsReq = 1'b0;
        rst       = 1'b1;
        expectN(1, E_STOP, FULL, "resetFromRqst");
        rst = 1'b0;
        expectN(1, E_STOP, FULL, "idleStop2");

`ifdef TX_TA_EN
        bus.HsReq = 1'b1;
        bus.TaReq = 1'b1;
        expectN(1, E_RQST, FULL, "hsBeatsTa");
        bus.HsReq = 1'b0;
        bus.TaReq = 1'b0;
        expectN(2, E_RQST, FULL, "hsBeatsTaHold");
        rst = 1'b1;
        expectN(1, E_STOP, FULL, "resetBeforeTa");
        rst = 1'b0;
        expectN(1, E_STOP, FULL, "idleBeforeTa");
        bus.TaReq = 1'b1;
        expectN(1, E_LPR, FULL, "lpRqstEntry");
        bus.TaReq = 1'b0;
        expectN(3, E_LPR, FULL, "lpRqstHold");
        expectN(4, E_TAR, FULL, "taRqst");
        expectN(5, E_TAGO, NO_ABC, "taGo");
        bus.TaReturn = 1'b1;
        expectN(1, E_STOP, FULL, "taReturn");
        bus.TaReturn = 1'b0;
        expectN(2, E_STOP, FULL, "stopAfterTa");
`else
        bus.TaReq = 1'b1;
        expectN(3, E_STOP, FULL, "taReqIgnored");
        bus.TaReq    = 1'b0;
        bus.TaReturn = 1'b1;
        expectN(1, E_STOP, FULL, "taReturnIgnored");
        bus.TaReturn = 1'b0;
        expectN(1, E_STOP, FULL, "idleEnd");
`endif

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL scoreboardDrain: got %0d pending entries, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
